maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
Depth-first maze-walk controller that sequences the 4-bit x/y location datapath (dir in, nxtLoc/cntReach out) over a 16x16 grid.
- Owns the current-location register, a visited bitmap and a direction stack for backtracking.
- Reads wall bits from an external 256x1 maze memory.
- Reports success/failure and path length to the top level.

Parameters:
START_LOC, 8'h00, entry cell {x[7:4], y[3:0]}
GOAL_LOC, 8'hFF, target cell
STACK_DEPTH, 256, direction stack entries (2 bits each); sp width = clog2(STACK_DEPTH)+1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin solve; sampled only in IDLE/DONE/FAIL
cntReach  input  1  datapath: move in dir would wrap past grid edge (illegal)
nxtLoc  input  8  datapath: combinational neighbour of curLoc in direction dir
memData  input  1  maze bit at memAddr, valid the cycle after memRd (1 = wall)
curLoc  output  8  current cell driven to datapath
dir  output  2  move direction: 00 y-1, 01 x+1, 10 x-1, 11 y+1; reverse(d) = ~d
rgLd  output  1  one-cycle pulse when curLoc commits a new cell
memRd  output  1  maze read strobe
memAddr  output  8  maze read address (= nxtLoc when memRd)
done  output  1  goal reached, held until next start
fail  output  1  no path / stack overflow, held until next start
pathLen  output  9  current stack depth = moves on path from START_LOC

Behaviour:
- Reset (async):
  - state=IDLE, curLoc=START_LOC, dir=00, sp=0, tryDir=00, visited cleared.
  - All strobes and done/fail = 0; pathLen = 0.
- States: IDLE, CHECK, WAIT, MOVE, ADVANCE, BACK, DONE, FAIL.
- IDLE/DONE/FAIL on start=1:
  - curLoc<=START_LOC, sp<=0, tryDir<=00, done/fail<=0.
  - Whole visited map cleared, then visited[START_LOC]<=1.
  - Next state CHECK.
- CHECK: dir=tryDir.
  - If curLoc==GOAL_LOC -> DONE.
  - Else if cntReach or visited[nxtLoc] -> ADVANCE.
  - Else assert memRd with memAddr=nxtLoc -> WAIT.
- WAIT: dir held = tryDir. memData=0 -> MOVE; memData=1 -> ADVANCE.
- MOVE:
  - If sp==STACK_DEPTH -> FAIL (overflow).
  - Else: rgLd=1, curLoc<=nxtLoc, push tryDir, visited[nxtLoc]<=1, tryDir<=00 -> CHECK.
- ADVANCE: if tryDir==11 -> BACK; else tryDir<=tryDir+1 -> CHECK.
- BACK:
  - If sp==0 -> FAIL.
  - Else d=stack[sp-1], dir=~d, rgLd=1, curLoc<=nxtLoc, sp<=sp-1, tryDir<=d -> ADVANCE.
  - Visited bits are never cleared during a run.
- DONE/FAIL: respective flag =1; curLoc, pathLen frozen.
- Cycle cost:
  - Rejected direction (edge/visited): 2 cycles (CHECK, ADVANCE).
  - Wall: 3 cycles.
  - Successful move: 3 cycles (CHECK, WAIT, MOVE).
  - Backtrack step: 2 cycles (BACK, ADVANCE).
- Simultaneous events:
  - start during CHECK..BACK ignored.
  - GOAL_LOC==START_LOC -> DONE one cycle after start, pathLen=0.
- Wall at START_LOC is not checked.
- Invariants:
  - With default STACK_DEPTH, overflow is unreachable (max 255 moves).
  - memRd and rgLd are never high in the same cycle.
- Reset mid-operation returns to IDLE immediately; outputs as reset values regardless of state.

Test Plan:
1. All-open maze, defaults, start pulse -> snake path (x+1 rows on even y, x-1 on odd y); done=1, curLoc=8'hFF, pathLen=240, fail=0, no BACK visits.
2. GOAL_LOC=START_LOC=8'h37 -> done=1 one cycle after start, pathLen=0, rgLd never asserted, memRd never asserted.
3. Maze all walls except (0,0) -> fail=1, pathLen=0, curLoc=8'h00, exactly 2 memRd strobes (dirs 01 and 11).
4. Dead-end corridor: open (1,0),(2,0) and column x=0 y=0..15, walls elsewhere, goal 8'h0F:
   - Walk reaches (2,0), backtracks twice with dir=10, then descends column.
   - done=1, pathLen=15.
5. STACK_DEPTH=4 on open maze -> fail=1 asserted in MOVE with pathLen=4.
6. Async rst asserted mid-walk (state WAIT) -> same-cycle IDLE, curLoc=8'h00, done=fail=0; start pulse during a run ignored (pathLen sequence unchanged vs. scenario 1).

Source files
------------

// File: rtl/maze_solver_ctrl.sv
// maze_solver_ctrl
// ----------------
// Depth-first maze-walk controller for a 16x16 grid. Cells are encoded as
// {x[7:4], y[3:0]}. The controller owns the current-location register, a
// visited bitmap and a direction stack used for backtracking. An external
// x/y datapath turns (curLoc, dir) into the neighbouring cell (nxtLoc) and
// flags moves that would wrap past the grid edge (cntReach). Wall bits come
// from an external 256x1 maze memory with one cycle of read latency.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   start     in   1  begin a solve; only looked at in IDLE/DONE/FAIL
//   cntReach  in   1  move in dir from curLoc would leave the grid
//   nxtLoc    in   8  neighbour of curLoc in direction dir
//   memData   in   1  wall bit for memAddr, valid the cycle after memRd
//   curLoc    out  8  current cell
//   dir       out  2  00 y-1, 01 x+1, 10 x-1, 11 y+1 (reverse of d is ~d)
//   rgLd      out  1  pulse when curLoc takes a new cell
//   memRd     out  1  maze read strobe
//   memAddr   out  8  maze read address (the neighbour cell)
//   done      out  1  goal reached, held until next start
//   fail      out  1  no path or stack overflow, held until next start
//   pathLen   out  9  number of moves on the current path (stack depth)

module maze_solver_ctrl #(
  parameter logic [7:0] START_LOC   = 8'h00,
  parameter logic [7:0] GOAL_LOC    = 8'hFF,
  parameter int         STACK_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cntReach,
  input  logic [7:0] nxtLoc,
  input  logic       memData,
  output logic [7:0] curLoc,
  output logic [1:0] dir,
  output logic       rgLd,
  output logic       memRd,
  output logic [7:0] memAddr,
  output logic       done,
  output logic       fail,
  output logic [8:0] pathLen
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_MOVE,
    S_ADVANCE,
    S_BACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t         state_reg, state_next;
  logic [7:0]     cur_reg, cur_next;
  logic [SPW-1:0] sp_reg, sp_next;
  logic [1:0]     try_reg, try_next;
  logic           done_reg, done_next;
  logic           fail_reg, fail_next;
  logic [255:0]   visited_reg;

  logic           visit_clr;
  logic           visit_set;
  logic           push_en;

  // Direction stack. Read asynchronously so BACK can undo a move in a
  // single cycle; it is small enough to live in distributed RAM.
  logic [1:0]     stack_mem [STACK_DEPTH];
  logic [SPW-1:0] sp_m1;
  logic [AW-1:0]  top_idx;
  logic [1:0]     top_dir;

  logic           stack_full;
  logic           stack_empty;
  logic           at_goal;
  logic           nxt_visited;

  assign sp_m1       = sp_reg - SPW'(1);
  assign top_idx     = sp_m1[AW-1:0];
  assign top_dir     = stack_mem[top_idx];
  assign stack_full  = (sp_reg == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_reg == '0);
  assign at_goal     = (cur_reg == GOAL_LOC);
  assign nxt_visited = visited_reg[nxtLoc];

  // ---------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    sp_next    = sp_reg;
    try_next   = try_reg;
    done_next  = done_reg;
    fail_next  = fail_reg;
    visit_clr  = 1'b0;
    visit_set  = 1'b0;
    push_en    = 1'b0;
    dir        = try_reg;
    rgLd       = 1'b0;
    memRd      = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_next   = START_LOC;
          sp_next    = '0;
          try_next   = 2'b00;
          done_next  = 1'b0;
          fail_next  = 1'b0;
          visit_clr  = 1'b1;
          state_next = S_CHECK;
        end
      end

      S_CHECK: begin
        if (at_goal) begin
          done_next  = 1'b1;
          state_next = S_DONE;
        end else if (cntReach || nxt_visited) begin
          // Edge or already explored: skip without touching memory.
          state_next = S_ADVANCE;
        end else begin
          memRd      = 1'b1;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        state_next = memData ? S_ADVANCE : S_MOVE;
      end

      S_MOVE: begin
        if (stack_full) begin
          fail_next  = 1'b1;
          state_next = S_FAIL;
        end else begin
          rgLd       = 1'b1;
          cur_next   = nxtLoc;
          push_en    = 1'b1;
          sp_next    = sp_reg + SPW'(1);
          visit_set  = 1'b1;
          try_next   = 2'b00;
          state_next = S_CHECK;
        end
      end

      S_ADVANCE: begin
        if (try_reg == 2'b11) begin
          state_next = S_BACK;
        end else begin
          try_next   = try_reg + 2'd1;
          state_next = S_CHECK;
        end
      end

      S_BACK: begin
        if (stack_empty) begin
          fail_next  = 1'b1;
          state_next = S_FAIL;
        end else begin
          // Step back along the reverse of the last pushed direction and
          // resume the search with the direction after it.
          dir        = ~top_dir;
          rgLd       = 1'b1;
          cur_next   = nxtLoc;
          sp_next    = sp_m1;
          try_next   = top_dir;
          state_next = S_ADVANCE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cur_reg   <= START_LOC;
      sp_reg    <= '0;
      try_reg   <= 2'b00;
      done_reg  <= 1'b0;
      fail_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      sp_reg    <= sp_next;
      try_reg   <= try_next;
      done_reg  <= done_next;
      fail_reg  <= fail_next;
    end
  end

  // Visited bitmap: cleared in one cycle at the start of a run (the start
  // cell is marked immediately), bits are only ever set during a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visited_reg <= '0;
    end else if (visit_clr) begin
      visited_reg            <= '0;
      visited_reg[START_LOC] <= 1'b1;
    end else if (visit_set) begin
      visited_reg[nxtLoc]    <= 1'b1;
    end
  end

  // Stack contents need no reset: sp bounds every read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_reg[AW-1:0]] <= try_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign curLoc  = cur_reg;
  assign memAddr = nxtLoc;
  assign done    = done_reg;
  assign fail    = fail_reg;
  assign pathLen = 9'(sp_reg);

  // A read and a location commit belong to different states.
  assert property (@(posedge clk) disable iff (rst) !(memRd && rgLd));

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// tb_maze_solver_ctrl
// -------------------
// Scoreboard bench for maze_solver_ctrl. Four instances with different
// parameters share one clock/reset; each has its own maze memory and x/y
// neighbour datapath. Before each run a depth-first reference walk computes
// the expected memory reads, location commits and final outcome (including
// the total cycle count) into a queue; a negedge monitor pops and compares
// whenever the selected instance strobes memRd/rgLd or raises done/fail.

`timescale 1ns/1ps

module tb_maze_solver_ctrl;

  localparam int NI    = 4;
  localparam int LIMIT = 10000;
  localparam logic [7:0] START_P [NI] = '{8'h00, 8'h00, 8'h37, 8'h00};
  localparam logic [7:0] GOAL_P  [NI] = '{8'hFF, 8'h0F, 8'h37, 8'hFF};
  localparam int         DEPTH_P [NI] = '{256, 256, 256, 4};

  localparam int K_RD   = 0;
  localparam int K_MV   = 1;
  localparam int K_DONE = 2;
  localparam int K_FAIL = 3;

  typedef struct {
    int         kind;
    logic [7:0] loc;
    logic [1:0] d;
    int         plen;
    int         cyc;
  } ev_t;

  logic            clk;
  logic            rst;
  logic [NI-1:0]   start;
  logic [NI-1:0]   cnt_reach;
  logic [NI-1:0]   mem_data;
  logic [NI-1:0]   rg_ld;
  logic [NI-1:0]   mem_rd;
  logic [NI-1:0]   done;
  logic [NI-1:0]   fail;
  logic [7:0]      nxt_loc  [NI];
  logic [7:0]      cur_loc  [NI];
  logic [1:0]      dir      [NI];
  logic [7:0]      mem_addr [NI];
  logic [8:0]      path_len [NI];

  logic            maze [NI][256];

  ev_t             exp_q [$];
  int              checks;
  int              errors;
  int              sel;
  bit              mon_en;
  int              run_id;
  int              term_run;
  time             t0;

  // Neighbour of loc in direction d, bit 8 set when the move leaves the grid.
  function automatic logic [8:0] step(input logic [7:0] loc, input logic [1:0] d);
    int         x;
    int         y;
    logic [8:0] r;
    x = int'(loc[7:4]);
    y = int'(loc[3:0]);
    case (d)
      2'd0:    y = y - 1;
      2'd1:    x = x + 1;
      2'd2:    x = x - 1;
      default: y = y + 1;
    endcase
    r[8]   = (x < 0) || (x > 15) || (y < 0) || (y > 15);
    r[7:4] = x[3:0];
    r[3:0] = y[3:0];
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      assign {cnt_reach[gi], nxt_loc[gi]} = step(cur_loc[gi], dir[gi]);

      maze_solver_ctrl #(
        .START_LOC  (START_P[gi]),
        .GOAL_LOC   (GOAL_P[gi]),
        .STACK_DEPTH(DEPTH_P[gi])
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start[gi]),
        .cntReach(cnt_reach[gi]),
        .nxtLoc  (nxt_loc[gi]),
        .memData (mem_data[gi]),
        .curLoc  (cur_loc[gi]),
        .dir     (dir[gi]),
        .rgLd    (rg_ld[gi]),
        .memRd   (mem_rd[gi]),
        .memAddr (mem_addr[gi]),
        .done    (done[gi]),
        .fail    (fail[gi]),
        .pathLen (path_len[gi])
      );
    end
  endgenerate

  // Maze memories: one cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mem_data[i] <= maze[i][mem_addr[i]];
    end
  end

  task automatic chk_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] loc, input logic [1:0] d,
                         input int plen, input int cyc);
    ev_t e;
    e.kind = kind;
    e.loc  = loc;
    e.d    = d;
    e.plen = plen;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Reference depth-first walk. Per attempt: edge/visited costs 2 cycles,
  // wall 3, move 3; each backtrack step 2; reaching the goal takes one
  // more check cycle, an empty-stack backtrack one cycle, an overflowing
  // move 3 cycles.
  task automatic build_expect(input int s);
    bit         vis [256];
    int         path [$];
    logic [7:0] cur;
    logic [8:0] nb;
    int         d;
    int         d0;
    int         cyc;
    bit         moved;
    bit         fin;
    exp_q.delete();
    for (int i = 0; i < 256; i++) vis[i] = 1'b0;
    cur      = START_P[s];
    vis[cur] = 1'b1;
    d        = 0;
    cyc      = 0;
    fin      = 1'b0;
    while (!fin) begin
      if (cur == GOAL_P[s]) begin
        cyc += 1;
        push_ev(K_DONE, cur, 2'd0, path.size(), cyc);
        fin = 1'b1;
      end else begin
        moved = 1'b0;
        while (d < 4 && !moved && !fin) begin
          nb = step(cur, 2'(d));
          if (nb[8] || vis[nb[7:0]]) begin
            cyc += 2;
            d++;
          end else begin
            push_ev(K_RD, nb[7:0], 2'(d), path.size(), 0);
            if (maze[s][nb[7:0]]) begin
              cyc += 3;
              d++;
            end else if (path.size() == DEPTH_P[s]) begin
              cyc += 3;
              push_ev(K_FAIL, cur, 2'd0, path.size(), cyc);
              fin = 1'b1;
            end else begin
              push_ev(K_MV, nb[7:0], 2'(d), path.size(), 0);
              path.push_back(d);
              vis[nb[7:0]] = 1'b1;
              cur   = nb[7:0];
              cyc  += 3;
              moved = 1'b1;
            end
          end
        end
        if (fin) begin
          // outcome already recorded
        end else if (moved) begin
          d = 0;
        end else if (path.size() == 0) begin
          cyc += 1;
          push_ev(K_FAIL, cur, 2'd0, 0, cyc);
          fin = 1'b1;
        end else begin
          d0 = path.pop_back();
          nb = step(cur, 2'(3 - d0));
          push_ev(K_MV, nb[7:0], 2'(3 - d0), path.size() + 1, 0);
          cur  = nb[7:0];
          cyc += 2;
          d    = d0 + 1;
        end
      end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (!rst && mon_en) begin
      if (mem_rd[sel] || rg_ld[sel]) begin
        chk_eq("rd_ld_exclusive", int'(mem_rd[sel] & rg_ld[sel]), 0);
        chk_eq("event_available", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (mem_rd[sel]) begin
            chk_eq("rd_kind", K_RD, e.kind);
            chk_eq("rd_addr", int'(mem_addr[sel]), int'(e.loc));
          end else begin
            chk_eq("move_kind", K_MV, e.kind);
            chk_eq("move_target", int'(nxt_loc[sel]), int'(e.loc));
          end
          chk_eq("event_dir", int'(dir[sel]), int'(e.d));
          chk_eq("event_pathlen", int'(path_len[sel]), e.plen);
        end
      end
      if ((done[sel] || fail[sel]) && term_run != run_id) begin
        term_run <= run_id;
        chk_eq("terminal_available", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_eq("term_done", int'(done[sel]), int'(e.kind == K_DONE));
          chk_eq("term_fail", int'(fail[sel]), int'(e.kind == K_FAIL));
          chk_eq("term_curloc", int'(cur_loc[sel]), int'(e.loc));
          chk_eq("term_pathlen", int'(path_len[sel]), e.plen);
          chk_eq("term_cycles", int'(($time - t0 - 5) / 10), e.cyc);
        end
      end
    end
  end

  task automatic kick(input int s);
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    t0 = $time;
    run_id++;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic run(input int s, input bit poke);
    int n;
    sel = s;
    build_expect(s);
    kick(s);
    n = 0;
    while (term_run != run_id && n < LIMIT) begin
      @(negedge clk);
      n++;
      // A start pulse in the middle of a walk must change nothing.
      start[s] = poke && (n == 40);
    end
    start[s] = 1'b0;
    chk_eq("terminal_in_budget", int'(n < LIMIT), 1);
    repeat (3) @(negedge clk);
    chk_eq("flag_held", int'(done[s] | fail[s]), 1);
    chk_eq("queue_drained", exp_q.size(), 0);
    $display("run inst=%0d done=%0d fail=%0d curLoc=%02h pathLen=%0d cycles_waited=%0d",
             s, done[s], fail[s], cur_loc[s], path_len[s], n);
  endtask

  task automatic fill_maze(input int s, input logic v);
    for (int a = 0; a < 256; a++) maze[s][a] = v;
  endtask

  initial begin
    int n;
    int rd;
    int dens;
    int s;
    checks   = 0;
    errors   = 0;
    sel      = 0;
    mon_en   = 1'b0;
    run_id   = 0;
    term_run = 0;
    t0       = 0;
    start    = '0;
    rst      = 1'b1;
    for (int i = 0; i < NI; i++) fill_maze(i, 1'b0);

    // Reset state of every instance
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk_eq("reset_curloc", int'(cur_loc[i]), int'(START_P[i]));
      chk_eq("reset_dir", int'(dir[i]), 0);
      chk_eq("reset_flags", int'({done[i], fail[i], rg_ld[i], mem_rd[i]}), 0);
      chk_eq("reset_pathlen", int'(path_len[i]), 0);
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Open maze: snake walk to FF, 240 moves
    run(0, 1'b0);
    chk_eq("snake_pathlen", int'(path_len[0]), 240);

    // Start cell is the goal
    run(2, 1'b0);

    // Every neighbour walled
    fill_maze(0, 1'b1);
    maze[0][8'h00] = 1'b0;
    run(0, 1'b0);

    // Dead-end corridor then column down to 0F
    fill_maze(1, 1'b1);
    maze[1][8'h10] = 1'b0;
    maze[1][8'h20] = 1'b0;
    for (int y = 0; y < 16; y++) maze[1][y] = 1'b0;
    run(1, 1'b0);
    chk_eq("corridor_pathlen", int'(path_len[1]), 15);

    // Tiny stack overflows on the open maze
    run(3, 1'b0);
    chk_eq("overflow_pathlen", int'(path_len[3]), 4);

    // Async reset while waiting on a maze read
    fill_maze(0, 1'b0);
    sel = 0;
    build_expect(0);
    kick(0);
    n  = 0;
    rd = 0;
    while (rd < 5 && n < 2000) begin
      @(negedge clk);
      n++;
      if (mem_rd[0]) rd++;
    end
    chk_eq("reached_fifth_read", rd, 5);
    chk_eq("pathlen_before_reset", int'(path_len[0]), 4);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk_eq("midrun_reset_curloc", int'(cur_loc[0]), 0);
    chk_eq("midrun_reset_flags", int'({done[0], fail[0], rg_ld[0], mem_rd[0]}), 0);
    chk_eq("midrun_reset_pathlen", int'(path_len[0]), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk_eq("idle_after_reset_pathlen", int'(path_len[0]), 0);
    $display("reset mid-walk: curLoc=%02h pathLen=%0d", cur_loc[0], path_len[0]);

    // Open maze again with a start pulse in the middle of the walk
    run(0, 1'b1);
    chk_eq("snake_pathlen_poked", int'(path_len[0]), 240);

    // Random mazes
    for (int r = 0; r < 9; r++) begin
      s    = (r % 3 == 2) ? 3 : (r % 2);
      dens = $urandom_range(45, 15);
      for (int a = 0; a < 256; a++) maze[s][a] = ($urandom_range(99, 0) < dens);
      run(s, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
